// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
//   Bundles the multiply-sequencer request/response signals with the ALU
//   control/result signals it drives and observes while busy.
//
//   Request side  : rdy, start, a_in, b_in
//   Response side : busy, done, product[15:0]
//   ALU control   : alu_op[3:0], alu_right, alu_ai[7:0], alu_bi[7:0], alu_ci,
//                   alu_bcd, alu_rdy
//   ALU result    : alu_out[7:0], alu_co (registered inside the ALU)
//
//   modport slave  : the sequencer itself
//   modport master : the surroundings (CPU side plus the shared ALU)
// -----------------------------------------------------------------------------
interface alu_mul_seq_if;
    // Request / response
    logic        rdy;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] product;

    // Shared ALU control
    logic [3:0]  alu_op;
    logic        alu_right;
    logic [7:0]  alu_ai;
    logic [7:0]  alu_bi;
    logic        alu_ci;
    logic        alu_bcd;
    logic        alu_rdy;

    // Shared ALU registered result
    logic [7:0]  alu_out;
    logic        alu_co;

    modport slave (
        input  rdy, start, a_in, b_in, alu_out, alu_co,
        output busy, done, product,
               alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
    );

    modport master (
        output rdy, start, a_in, b_in, alu_out, alu_co,
        input  busy, done, product,
               alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Unsigned 8x8 -> 16-bit multiplier that owns no adder of its own: it
//   time-multiplexes the CPU's 8-bit ALU using shift-add. For every multiplier
//   bit (LSB first) it optionally adds the multiplicand into the high byte,
//   then rotates the 9-bit {carry,hi} right into hi and hi[0] into lo via two
//   ALU rotate-right passes. The multiplier lives in lo and is shifted out as
//   the product's low byte is shifted in.
//
//   The ALU result is registered, so each pass reads the previous pass's
//   result in the following state. Global rdy freezes both this sequencer and
//   the ALU (via alu_rdy), which keeps that one-cycle pairing intact.
//
// Ports
//   clk    : system clock, all state on rising edge
//   reset  : asynchronous, active-high reset
//   bus    : alu_mul_seq_if.slave
//            rdy/start/a_in/b_in in; busy/done/product out;
//            alu_* control out; alu_out/alu_co registered ALU result in
//
// Latency: 3 cycles per multiplier bit plus 1 for each set bit, i.e. done
// rises 24 + popcount(b_in) unstalled edges after the accepting edge.
// -----------------------------------------------------------------------------
module alu_mul_seq (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_ROR_H,
        S_ROR_L,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_IDLE = 4'b1111;

    // State and datapath registers
    state_t      r_state;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic [7:0]  r_mcand;
    logic [2:0]  r_cnt;
    logic        r_added;
    logic [15:0] r_product;
    logic        r_done;

    // Combinational next state and ALU drive
    state_t      w_state_nxt;
    logic [3:0]  w_alu_op;
    logic        w_alu_right;
    logic [7:0]  w_alu_ai;
    logic [7:0]  w_alu_bi;
    logic        w_alu_ci;
    logic        w_accept;
    logic        w_last_bit;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_last_bit = (r_cnt == 3'd7);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (bus.rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and ALU control (purely a function of state and ALU result)
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_alu_op    = OP_IDLE;
        w_alu_right = 1'b0;
        w_alu_ai    = 8'h00;
        w_alu_bi    = 8'h00;
        w_alu_ci    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The first multiplier bit comes straight from the input;
                // later bits come from the rotated-out low byte.
                if (bus.start) begin
                    w_state_nxt = bus.b_in[0] ? S_ADD : S_ROR_H;
                end
            end

            S_ADD: begin
                w_alu_op    = OP_ADD;
                w_alu_ai    = r_hi;
                w_alu_bi    = r_mcand;
                w_state_nxt = S_ROR_H;
            end

            S_ROR_H: begin
                // After an ADD the 9-bit sum sits in {alu_co, alu_out}; rotating
                // it with CI=carry keeps the ninth bit. Without an ADD the high
                // byte is rotated with a zero shifted in.
                w_alu_right = 1'b1;
                w_alu_ai    = r_added ? bus.alu_out : r_hi;
                w_alu_ci    = r_added & bus.alu_co;
                w_state_nxt = S_ROR_L;
            end

            S_ROR_L: begin
                // alu_co now holds the bit that fell out of the high byte;
                // it becomes the new MSB of the low byte.
                w_alu_right = 1'b1;
                w_alu_ai    = r_lo;
                w_alu_ci    = bus.alu_co;
                w_state_nxt = S_NEXT;
            end

            S_NEXT: begin
                // alu_out is the freshly rotated low byte; its bit 0 is the
                // next multiplier bit to consume.
                if (w_last_bit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = bus.alu_out[0] ? S_ADD : S_ROR_H;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi      <= 8'h00;
            r_lo      <= 8'h00;
            r_mcand   <= 8'h00;
            r_cnt     <= 3'd0;
            r_added   <= 1'b0;
            r_product <= 16'h0000;
            r_done    <= 1'b0;
        end else if (bus.rdy) begin
            // done is high exactly while the FSM sits in DONE
            r_done <= (w_state_nxt == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= bus.a_in;
                        r_lo    <= bus.b_in;
                        r_hi    <= 8'h00;
                        r_cnt   <= 3'd0;
                        r_added <= 1'b0;
                    end
                end

                S_ADD: begin
                    r_added <= 1'b1;
                end

                S_ROR_L: begin
                    r_hi    <= bus.alu_out;
                    r_added <= 1'b0;
                end

                S_NEXT: begin
                    r_lo <= bus.alu_out;
                    if (w_last_bit) begin
                        // Publish on the same edge that enters DONE so product
                        // is already valid in the cycle done is high.
                        r_product <= {r_hi, bus.alu_out};
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done      = r_done;
    assign bus.product   = r_product;

    assign bus.alu_op    = w_alu_op;
    assign bus.alu_right = w_alu_right;
    assign bus.alu_ai    = w_alu_ai;
    assign bus.alu_bi    = w_alu_bi;
    assign bus.alu_ci    = w_alu_ci;
    assign bus.alu_bcd   = 1'b0;
    assign bus.alu_rdy   = bus.rdy;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
//   Environment: a small registered ALU model (ADD and rotate-right) that the
//   sequencer drives. Reference: an operation-level model that knows only that
//   an accepted request yields a*b after 24+popcount(b) unstalled cycles, with
//   popcount(b) ADD operations issued to the ALU. Directed cases pin both DUT
//   and model against hand-computed products and done edges; a random phase
//   then exercises start/rdy/operand combinations.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Shared ALU model: one-cycle registered result, holds when alu_rdy=0.
    // -------------------------------------------------------------------------
    logic [7:0] alu_q = 8'h00;
    logic       alu_c = 1'b0;

    always @(posedge clk) begin
        if (bus.alu_rdy === 1'b1) begin
            if (bus.alu_right) begin
                alu_q <= {bus.alu_ci, bus.alu_ai[7:1]};
                alu_c <= bus.alu_ai[0];
            end else if (bus.alu_op == 4'b0011) begin
                {alu_c, alu_q} <= 9'(bus.alu_ai) + 9'(bus.alu_bi) + 9'(bus.alu_ci);
            end else begin
                alu_q <= bus.alu_ai;
                alu_c <= 1'b0;
            end
        end
    end

    assign bus.alu_out = alu_q;
    assign bus.alu_co  = alu_c;

    // -------------------------------------------------------------------------
    // Operation-level reference model
    // -------------------------------------------------------------------------
    typedef enum {M_IDLE, M_RUN, M_DONE} m_phase_t;

    m_phase_t    m_phase    = M_IDLE;
    int          m_left     = 0;
    int          m_adds     = 0;
    int          m_exp_adds = 0;
    logic [15:0] m_pend     = 16'h0000;
    logic [15:0] m_prod     = 16'h0000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_IDLE;
            m_prod  = 16'h0000;
            m_left  = 0;
        end else if (bus.rdy) begin
            case (m_phase)
                M_IDLE: begin
                    if (bus.start) begin
                        m_pend     = 16'(bus.a_in) * 16'(bus.b_in);
                        m_exp_adds = $countones(bus.b_in);
                        m_left     = 24 + m_exp_adds;
                        m_adds     = 0;
                        m_phase    = M_RUN;
                    end
                end
                M_RUN: begin
                    if (bus.alu_op == 4'b0011) m_adds++;
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = M_DONE;
                        m_prod  = m_pend;
                        check("add_count", 32'(m_adds), 32'(m_exp_adds));
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Cycle compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    32'(bus.busy),    32'(m_phase == M_RUN));
            check("done",    32'(bus.done),    32'(m_phase == M_DONE));
            check("product", 32'(bus.product), 32'(m_prod));
            check("alu_rdy", 32'(bus.alu_rdy), 32'(bus.rdy));
            check("alu_bcd", 32'(bus.alu_bcd), 32'd0);
        end
    end

    // -------------------------------------------------------------------------
    // Directed operation: returns #1 after the edge on which done is seen.
    // -------------------------------------------------------------------------
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int exp_edges,
                          input int stall_at, input int stall_len,
                          input bit extra_start);
        int n;
        bit seen;
        @(posedge clk); #1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (stall_len > 0 && n == stall_at) bus.rdy = 1'b0;
            if (stall_len > 0 && n == stall_at + stall_len) bus.rdy = 1'b1;
            if (stall_len > 0 && n > stall_at && n < stall_at + stall_len)
                check("alu_rdy_stall", 32'(bus.alu_rdy), 32'd0);
            if (extra_start && n == 5) begin
                bus.a_in  = 8'h02;
                bus.b_in  = 8'h02;
                bus.start = 1'b1;
            end
            if (extra_start && n == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("done_edge",   32'(n),           32'(exp_edges));
        check("product_lit", 32'(bus.product), 32'(exp_p));
        check("model_lit",   32'(m_prod),      32'(exp_p));
    endtask

    initial begin
        bus.rdy   = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = 8'h00;
        bus.b_in  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_done",    32'(bus.done),      32'd0);
        check("rst_product", 32'(bus.product),   32'd0);
        check("rst_alu_op",  32'(bus.alu_op),    32'hF);
        check("rst_right",   32'(bus.alu_right), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        run_op(8'h00, 8'h00, 16'h0000, 24, 0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 16'hFE01, 32, 0, 0, 1'b0);
        run_op(8'h0D, 8'h0B, 16'h008F, 27, 0, 0, 1'b1);
        run_op(8'h80, 8'h02, 16'h0100, 30, 10, 5, 1'b0);

        // Reset in the middle of an operation
        @(posedge clk); #1;
        bus.a_in  = 8'h12;
        bus.b_in  = 8'h34;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy",    32'(bus.busy),    32'd0);
        check("midrst_done",    32'(bus.done),    32'd0);
        check("midrst_product", 32'(bus.product), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(8'h03, 8'h05, 16'h000F, 26, 0, 0, 1'b0);

        // Back-to-back: second start lands in the IDLE cycle right after DONE
        run_op(8'h10, 8'h10, 16'h0100, 25, 0, 0, 1'b0);
        run_op(8'h01, 8'h01, 16'h0001, 25, 0, 0, 1'b0);

        // Random phase: random operands, start and rdy; model checks each cycle
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            bus.rdy   = ($urandom_range(0, 7) != 0);
            bus.start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       bus.a_in = 8'hFF;
                1:       bus.a_in = 8'h00;
                default: bus.a_in = 8'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       bus.b_in = 8'hFF;
                1:       bus.b_in = 8'h00;
                default: bus.b_in = 8'($urandom);
            endcase
        end

        bus.rdy   = 1'b1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
